fpu_op_sequencer: RTL and testbench
===================================

# fpu_op_sequencer

Issue sequencer between the decode stage and the bfloat16 FPU execution unit. It buffers decoded FPU operations with their operands in a small FIFO and issues them to the FPU one at a time. It waits for single- or multi-cycle completion, bounded by a timeout, then delivers the result to the FP or integer register file via a valid/ready writeback handshake. It also accumulates the sticky exception flags (fflags).

## Interface
Parameters:
- DEPTH, 2: op FIFO entries (power of two, ≥2)
- TIMEOUT, 31: max WAIT cycles before abort (1..255)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  decoded FPU op available
- req_ready  out  1  FIFO can accept (= not full)
- req_op  in  24  sfpu_op one-hot operation code
- req_ctrl  in  4  float_control
- req_rnd  in  3  rounding mode
- req_pre  in  3  precision select
- req_sel  in  3  fpu_sel
- req_fs1 / req_fs2 / req_fs3  in  16 each  bfloat16 operands
- req_rd  in  5  destination register
- req_int  in  1  1 = integer (GPR) destination
- exu_valid  out  1  one-cycle issue pulse to the FPU (valid_execution)
- exu_op, exu_ctrl, exu_rnd, exu_pre, exu_sel, exu_fs1..3  out  24/4/3/3/3/16  held fields of the issued op
- exu_result  in  16  FP result
- exu_result_rd  in  32  integer result
- exu_complete  in  1  FP result valid
- exu_complete_rd  in  1  integer result valid
- exu_flags  in  5  {NV,DZ,OF,UF,NX} for the completing op
- exu_iv  in  1  invalid-operation exception
- wb_valid  out  1  writeback pending
- wb_ready  in  1  register file accepts
- wb_rd  out  5  destination register
- wb_int  out  1  GPR destination
- wb_data  out  32  result; FP results are zero-extended from 16 bits
- wb_iv  out  1  exu_iv captured with the result
- fflags  out  5  sticky OR of accepted exu_flags
- fflags_clr  in  1  clear fflags
- busy  out  1  state ≠ IDLE or FIFO non-empty
- timeout_err  out  1  sticky; set on timeout, cleared only by rst

## Operation
- FSM states: IDLE, ISSUE, WAIT, WB.
- IDLE → ISSUE when the FIFO is non-empty. The head entry is popped into the issue register on that transition.
- ISSUE lasts one cycle. exu_valid=1 and the exu_* fields are driven from the issue register.
- Completion qualifier: exu_complete_rd when the issued op has req_int=1, otherwise exu_complete. The other strobe is ignored.
- A qualifier seen in ISSUE or WAIT does four things:
  - capture wb_data, wb_iv, wb_rd, wb_int;
  - fflags |= exu_flags;
  - go to WB;
  - clear the timeout counter.
- ISSUE with no qualifier → WAIT. The counter increments every WAIT cycle.
- Counter reaches TIMEOUT in WAIT → go to WB with wb_data=0 and wb_iv=0, set timeout_err, fflags unchanged.
- WB holds wb_valid=1 with stable outputs until wb_ready=1. On that cycle:
  - next state is ISSUE if the FIFO is non-empty, with the pop happening on that edge;
  - otherwise IDLE.
- FIFO:
  - push on req_valid & req_ready;
  - push and pop in the same cycle are both honoured;
  - req_ready depends only on the registered full flag, so no push is accepted when full, even if a pop is concurrent;
  - read/write pointers wrap modulo DEPTH.
- fflags_clr and accumulate in the same cycle: the result is the new exu_flags only (clear first, then OR).
- Completion strobes in IDLE or WB are ignored.

## Timing
- Reset values: every output 0, FIFO empty, state IDLE, counter 0. req_ready=1 from the first cycle after rst deasserts.
- rst asserted mid-operation aborts immediately. The in-flight op and all FIFO contents are discarded, and no writeback occurs.
- Minimum latency is 3 cycles from the push edge to wb_valid:
  - push edge;
  - IDLE→ISSUE pop edge;
  - a same-cycle completion in ISSUE → WB on the next edge.
- Back-to-back throughput is one op per 2 cycles (ISSUE, WB) when wb_ready is held at 1.
- exu_* fields stay stable from ISSUE until leaving WAIT. exu_valid is never high for more than one cycle per op.

## Structure
- Shared package fpu_seq_pkg holds:
  - FSM state encoding;
  - fflags bit positions (NV=4, DZ=3, OF=2, UF=1, NX=0);
  - FIFO entry field widths and the packed entry width (24+4+3+3+3+48+5+1 = 91).
- Sub-module fpu_seq_fifo: parameterised synchronous FIFO with full/empty flags and wrap-around pointers.
- The FSM, counter and flag logic live in the top module.

## Test plan
- Single FP op: push op fs1=3F80 and fs2=4000, rd=5. The model completes in ISSUE with result 4040 and flags 00001.
  - Expect exactly one exu_valid pulse.
  - Expect wb_valid at cycle 3 with wb_data=00004040, wb_rd=5, wb_int=0, fflags=00001.
- Integer-result op: req_int=1, model returns exu_complete_rd after 4 cycles with exu_result_rd=0000002A. Also pulse exu_complete during the wait.
  - Expect the FP strobe to be ignored.
  - Expect wb_data=0000002A, wb_int=1.
- FIFO full and back-pressure: hold wb_ready=0 and push 3 ops.
  - Expect req_ready=0 after 2 accepted pushes.
  - Expect ops to be written back in push order once wb_ready=1, one per 2 cycles.
- Timeout: the model never completes, TIMEOUT=31.
  - Expect WB after 31 WAIT cycles with wb_data=0 and timeout_err=1.
  - Expect the next op to still be issued normally.
- Flag clear collision: fflags=10000, then fflags_clr on the same cycle as a completion with flags 00100. Expect fflags=00100.
- Reset mid-WAIT: assert rst while in WAIT with 1 op queued.
  - Expect all outputs 0 and busy=0.
  - Expect a late exu_complete after reset to produce no wb_valid.

Source files
------------

// File: rtl/fpu_seq_pkg.sv
// Shared types and constants for the bfloat16 FPU issue sequencer.
package fpu_seq_pkg;

    localparam int unsigned OP_W    = 24;
    localparam int unsigned CTRL_W  = 4;
    localparam int unsigned RND_W   = 3;
    localparam int unsigned PRE_W   = 3;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned FP_W    = 16;
    localparam int unsigned RD_W    = 5;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned FLAG_W  = 5;
    localparam int unsigned ENTRY_W = OP_W + CTRL_W + RND_W + PRE_W + SEL_W + 3 * FP_W + RD_W + 1;

    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [CTRL_W-1:0] ctrl;
        logic [RND_W-1:0]  rnd;
        logic [PRE_W-1:0]  pre;
        logic [SEL_W-1:0]  sel;
        logic [FP_W-1:0]   fs1;
        logic [FP_W-1:0]   fs2;
        logic [FP_W-1:0]   fs3;
        logic [RD_W-1:0]   rd;
        logic              is_int;
    } fpu_entry_t;

endpackage

// File: rtl/fpu_op_sequencer_if.sv
// Request, FPU execution and writeback signals of the sequencer.
interface fpu_op_sequencer_if;
    import fpu_seq_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [CTRL_W-1:0] req_ctrl;
    logic [RND_W-1:0]  req_rnd;
    logic [PRE_W-1:0]  req_pre;
    logic [SEL_W-1:0]  req_sel;
    logic [FP_W-1:0]   req_fs1;
    logic [FP_W-1:0]   req_fs2;
    logic [FP_W-1:0]   req_fs3;
    logic [RD_W-1:0]   req_rd;
    logic              req_int;

    logic              exu_valid;
    logic [OP_W-1:0]   exu_op;
    logic [CTRL_W-1:0] exu_ctrl;
    logic [RND_W-1:0]  exu_rnd;
    logic [PRE_W-1:0]  exu_pre;
    logic [SEL_W-1:0]  exu_sel;
    logic [FP_W-1:0]   exu_fs1;
    logic [FP_W-1:0]   exu_fs2;
    logic [FP_W-1:0]   exu_fs3;
    logic [FP_W-1:0]   exu_result;
    logic [XLEN-1:0]   exu_result_rd;
    logic              exu_complete;
    logic              exu_complete_rd;
    logic [FLAG_W-1:0] exu_flags;
    logic              exu_iv;

    logic              wb_valid;
    logic              wb_ready;
    logic [RD_W-1:0]   wb_rd;
    logic              wb_int;
    logic [XLEN-1:0]   wb_data;
    logic              wb_iv;

    logic [FLAG_W-1:0] fflags;
    logic              fflags_clr;
    logic              busy;
    logic              timeout_err;

    // Environment side: decode stage, FPU model and register file
    modport master (
        output req_valid, req_op, req_ctrl, req_rnd, req_pre, req_sel,
               req_fs1, req_fs2, req_fs3, req_rd, req_int,
        input  req_ready,
        input  exu_valid, exu_op, exu_ctrl, exu_rnd, exu_pre, exu_sel,
               exu_fs1, exu_fs2, exu_fs3,
        output exu_result, exu_result_rd, exu_complete, exu_complete_rd, exu_flags, exu_iv,
        input  wb_valid, wb_rd, wb_int, wb_data, wb_iv,
        output wb_ready,
        input  fflags, busy, timeout_err,
        output fflags_clr
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_ctrl, req_rnd, req_pre, req_sel,
               req_fs1, req_fs2, req_fs3, req_rd, req_int,
        output req_ready,
        output exu_valid, exu_op, exu_ctrl, exu_rnd, exu_pre, exu_sel,
               exu_fs1, exu_fs2, exu_fs3,
        input  exu_result, exu_result_rd, exu_complete, exu_complete_rd, exu_flags, exu_iv,
        output wb_valid, wb_rd, wb_int, wb_data, wb_iv,
        input  wb_ready,
        output fflags, busy, timeout_err,
        input  fflags_clr
    );

endinterface

// File: rtl/fpu_seq_fifo.sv
// Synchronous FIFO with wrap-bit pointers; full/empty derived from pointer registers only.
module fpu_seq_fifo #(
    parameter int unsigned WIDTH = 91,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Equal index with opposite wrap bits means every slot is occupied
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Buffers decoded FPU ops, issues them one at a time, waits for completion or timeout,
// and hands the result to the register file while accumulating sticky fflags.
module fpu_op_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 31
) (
    input  logic                clk,
    input  logic                rst,
    fpu_op_sequencer_if.slave   bus
);

    localparam int unsigned CNT_W = 8;

    state_t            r_state;
    state_t            w_state_nxt;
    fpu_entry_t        w_push_entry;
    fpu_entry_t        w_head;
    fpu_entry_t        r_issue;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_qual;
    logic              w_accept;
    logic              w_timeout;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_wb_data;
    logic              r_wb_iv;
    logic [RD_W-1:0]   r_wb_rd;
    logic              r_wb_int;
    logic [FLAG_W-1:0] r_fflags;
    logic              r_timeout_err;

    assign w_push_entry = '{op: bus.req_op, ctrl: bus.req_ctrl, rnd: bus.req_rnd,
                            pre: bus.req_pre, sel: bus.req_sel, fs1: bus.req_fs1,
                            fs2: bus.req_fs2, fs3: bus.req_fs3, rd: bus.req_rd,
                            is_int: bus.req_int};

    fpu_seq_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (bus.req_valid),
        .i_wr_data (w_push_entry),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Only the strobe matching the issued op's destination counts
    assign w_qual = r_issue.is_int ? bus.exu_complete_rd : bus.exu_complete;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_ISSUE;
                    w_pop       = 1'b1;
                end
            end
            S_ISSUE: begin
                if (w_qual) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WB;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_qual) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WB;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_WB;
                end
            end
            S_WB: begin
                if (bus.wb_ready) begin
                    if (!w_empty) begin
                        w_state_nxt = S_ISSUE;
                        w_pop       = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_issue       <= '0;
            r_cnt         <= '0;
            r_wb_data     <= '0;
            r_wb_iv       <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_int      <= 1'b0;
            r_fflags      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) r_issue <= w_head;
            r_cnt <= (r_state == S_WAIT && w_state_nxt == S_WAIT) ? r_cnt + CNT_W'(1) : '0;
            if (w_accept) begin
                r_wb_data <= r_issue.is_int ? bus.exu_result_rd : XLEN'(bus.exu_result);
                r_wb_iv   <= bus.exu_iv;
                r_wb_rd   <= r_issue.rd;
                r_wb_int  <= r_issue.is_int;
            end else if (w_timeout) begin
                r_wb_data     <= '0;
                r_wb_iv       <= 1'b0;
                r_wb_rd       <= r_issue.rd;
                r_wb_int      <= r_issue.is_int;
                r_timeout_err <= 1'b1;
            end
            // Clear takes effect before a same-cycle accumulate
            if (bus.fflags_clr)  r_fflags <= w_accept ? bus.exu_flags : '0;
            else if (w_accept)   r_fflags <= r_fflags | bus.exu_flags;
        end
    end

    assign bus.req_ready   = ~w_full & ~rst;
    assign bus.exu_valid   = (r_state == S_ISSUE);
    assign bus.exu_op      = r_issue.op;
    assign bus.exu_ctrl    = r_issue.ctrl;
    assign bus.exu_rnd     = r_issue.rnd;
    assign bus.exu_pre     = r_issue.pre;
    assign bus.exu_sel     = r_issue.sel;
    assign bus.exu_fs1     = r_issue.fs1;
    assign bus.exu_fs2     = r_issue.fs2;
    assign bus.exu_fs3     = r_issue.fs3;
    assign bus.wb_valid    = (r_state == S_WB);
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_int      = r_wb_int;
    assign bus.wb_data     = r_wb_data;
    assign bus.wb_iv       = r_wb_iv;
    assign bus.fflags      = r_fflags;
    assign bus.busy        = (r_state != S_IDLE) | ~w_empty;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer: one task per scenario with hand-computed expectations.
module tb_fpu_op_sequencer;
    import fpu_seq_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    fpu_op_sequencer_if bus ();

    fpu_op_sequencer #(.DEPTH(2), .TIMEOUT(31)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [4:0] rd, input logic is_int,
                             input logic [15:0] fs1, input logic [15:0] fs2);
        bus.req_valid = 1'b1;
        bus.req_op    = 24'h000010;
        bus.req_ctrl  = 4'h3;
        bus.req_rnd   = 3'd1;
        bus.req_pre   = 3'd2;
        bus.req_sel   = 3'd4;
        bus.req_fs1   = fs1;
        bus.req_fs2   = fs2;
        bus.req_fs3   = 16'h0000;
        bus.req_rd    = rd;
        bus.req_int   = is_int;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); end
        n_cmp++; if (bus.exu_valid !== 1'b0) begin n_fail++; $display("FAIL rst_exu_valid: got %b want 0", bus.exu_valid); end
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid: got %b want 0", bus.wb_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.fflags !== 5'b00000) begin n_fail++; $display("FAIL rst_fflags: got %b want 00000", bus.fflags); end
        n_cmp++; if (bus.wb_data !== 32'h0) begin n_fail++; $display("FAIL rst_wb_data: got %h want 0", bus.wb_data); end
        n_cmp++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err: got %b want 0", bus.timeout_err); end
        rst = 1'b0;
        tick();
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_ready: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_single_fp();
        bus.exu_result   = 16'h4040;
        bus.exu_flags    = 5'b00001;
        bus.exu_complete = 1'b1;
        drive_req(5'd5, 1'b0, 16'h3F80, 16'h4000);
        tick();                                   // push edge
        bus.req_valid = 1'b0;
        n_cmp++; if (bus.exu_valid !== 1'b0) begin n_fail++; $display("FAIL fp_exu_valid_c1: got %b want 0", bus.exu_valid); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL fp_busy_c1: got %b want 1", bus.busy); end
        tick();                                   // ISSUE
        n_cmp++; if (bus.exu_valid !== 1'b1) begin n_fail++; $display("FAIL fp_exu_valid_c2: got %b want 1", bus.exu_valid); end
        n_cmp++; if (bus.exu_fs1 !== 16'h3F80 || bus.exu_fs2 !== 16'h4000) begin n_fail++; $display("FAIL fp_exu_fs: got %h/%h want 3f80/4000", bus.exu_fs1, bus.exu_fs2); end
        tick();                                   // WB
        n_cmp++; if (bus.exu_valid !== 1'b0) begin n_fail++; $display("FAIL fp_exu_valid_c3: got %b want 0", bus.exu_valid); end
        n_cmp++; if (bus.wb_valid !== 1'b1) begin n_fail++; $display("FAIL fp_wb_valid: got %b want 1", bus.wb_valid); end
        n_cmp++; if (bus.wb_data !== 32'h00004040) begin n_fail++; $display("FAIL fp_wb_data: got %h want 00004040", bus.wb_data); end
        n_cmp++; if (bus.wb_rd !== 5'd5 || bus.wb_int !== 1'b0) begin n_fail++; $display("FAIL fp_wb_rd_int: got %0d/%b want 5/0", bus.wb_rd, bus.wb_int); end
        n_cmp++; if (bus.fflags !== 5'b00001) begin n_fail++; $display("FAIL fp_fflags: got %b want 00001", bus.fflags); end
        tick();                                   // stalled, wb_ready low
        n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h00004040) begin n_fail++; $display("FAIL fp_wb_hold: got %b/%h want 1/00004040", bus.wb_valid, bus.wb_data); end
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready     = 1'b0;
        bus.exu_complete = 1'b0;
        n_cmp++; if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL fp_idle: got wb_valid %b busy %b want 0/0", bus.wb_valid, bus.busy); end
        n_cmp++; if (bus.fflags !== 5'b00001) begin n_fail++; $display("FAIL fp_fflags_once: got %b want 00001", bus.fflags); end
    endtask

    task automatic test_int_op();
        bus.exu_flags = 5'b00000;
        drive_req(5'd7, 1'b1, 16'h1234, 16'h5678);
        tick();
        bus.req_valid = 1'b0;
        tick();                                   // ISSUE, no completion
        n_cmp++; if (bus.exu_valid !== 1'b1) begin n_fail++; $display("FAIL int_exu_valid: got %b want 1", bus.exu_valid); end
        bus.exu_complete = 1'b1;                  // wrong strobe for an integer op
        bus.exu_result   = 16'hBEEF;
        tick();                                   // WAIT
        bus.exu_complete = 1'b0;
        n_cmp++; if (bus.exu_valid !== 1'b0 || bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL int_wait1: got exu_valid %b wb_valid %b want 0/0", bus.exu_valid, bus.wb_valid); end
        tick();
        n_cmp++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL int_fp_strobe_ignored: got %b want 0", bus.wb_valid); end
        n_cmp++; if (bus.exu_op !== 24'h000010 || bus.exu_fs1 !== 16'h1234 || bus.exu_ctrl !== 4'h3) begin n_fail++; $display("FAIL int_exu_stable: got %h/%h/%h want 000010/1234/3", bus.exu_op, bus.exu_fs1, bus.exu_ctrl); end
        tick();
        bus.exu_complete_rd = 1'b1;
        bus.exu_result_rd   = 32'h0000002A;
        bus.exu_iv          = 1'b1;
        bus.exu_flags       = 5'b00010;
        tick();                                   // WB
        bus.exu_complete_rd = 1'b0;
        bus.exu_iv          = 1'b0;
        bus.exu_flags       = 5'b00000;
        n_cmp++; if (bus.wb_valid !== 1'b1) begin n_fail++; $display("FAIL int_wb_valid: got %b want 1", bus.wb_valid); end
        n_cmp++; if (bus.wb_data !== 32'h0000002A) begin n_fail++; $display("FAIL int_wb_data: got %h want 0000002a", bus.wb_data); end
        n_cmp++; if (bus.wb_int !== 1'b1 || bus.wb_rd !== 5'd7 || bus.wb_iv !== 1'b1) begin n_fail++; $display("FAIL int_wb_fields: got int %b rd %0d iv %b want 1/7/1", bus.wb_int, bus.wb_rd, bus.wb_iv); end
        n_cmp++; if (bus.fflags !== 5'b00011) begin n_fail++; $display("FAIL int_fflags: got %b want 00011", bus.fflags); end
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
    endtask

    task automatic test_fifo_full();
        bus.exu_complete = 1'b1;
        bus.exu_result   = 16'h1111;
        bus.exu_flags    = 5'b00000;
        drive_req(5'd1, 1'b0, 16'h0001, 16'h0000);
        tick();                                   // op1 pushed
        drive_req(5'd2, 1'b0, 16'h0002, 16'h0000);
        tick();                                   // op2 pushed, op1 issued
        drive_req(5'd3, 1'b0, 16'h0003, 16'h0000);
        tick();                                   // op3 pushed, op1 to WB
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL full_req_ready: got %b want 0", bus.req_ready); end
        drive_req(5'd4, 1'b0, 16'h0004, 16'h0000);
        tick();
        n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd1) begin n_fail++; $display("FAIL full_wb1: got %b rd %0d want 1 rd 1", bus.wb_valid, bus.wb_rd); end
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL full_req_ready_hold: got %b want 0", bus.req_ready); end
        tick();
        bus.wb_ready = 1'b1;
        tick();                                   // pop op2 while full: op4 must be refused
        bus.req_valid = 1'b0;
        n_cmp++; if (bus.exu_valid !== 1'b1 || bus.exu_fs1 !== 16'h0002) begin n_fail++; $display("FAIL full_issue2: got %b fs1 %h want 1 fs1 0002", bus.exu_valid, bus.exu_fs1); end
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL full_req_ready_free: got %b want 1", bus.req_ready); end
        tick();
        n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd2) begin n_fail++; $display("FAIL full_wb2: got %b rd %0d want 1 rd 2", bus.wb_valid, bus.wb_rd); end
        tick();
        n_cmp++; if (bus.exu_valid !== 1'b1 || bus.exu_fs1 !== 16'h0003) begin n_fail++; $display("FAIL full_issue3: got %b fs1 %h want 1 fs1 0003", bus.exu_valid, bus.exu_fs1); end
        tick();
        n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd3) begin n_fail++; $display("FAIL full_wb3: got %b rd %0d want 1 rd 3", bus.wb_valid, bus.wb_rd); end
        tick();
        n_cmp++; if (bus.busy !== 1'b0 || bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got busy %b wb_valid %b want 0/0", bus.busy, bus.wb_valid); end
        bus.wb_ready     = 1'b0;
        bus.exu_complete = 1'b0;
    endtask

    task automatic test_timeout();
        bus.exu_result = 16'hFFFF;
        bus.exu_iv     = 1'b1;
        drive_req(5'd9, 1'b0, 16'h4444, 16'h0000);
        tick();
        bus.req_valid = 1'b0;
        repeat (32) tick();                       // ISSUE plus 30 WAIT cycles elapsed
        n_cmp++; if (bus.wb_valid !== 1'b0 || bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_early: got wb_valid %b err %b want 0/0", bus.wb_valid, bus.timeout_err); end
        tick();
        n_cmp++; if (bus.wb_valid !== 1'b1) begin n_fail++; $display("FAIL to_wb_valid: got %b want 1", bus.wb_valid); end
        n_cmp++; if (bus.wb_data !== 32'h0 || bus.wb_iv !== 1'b0 || bus.wb_rd !== 5'd9) begin n_fail++; $display("FAIL to_wb_fields: got %h iv %b rd %0d want 0 iv 0 rd 9", bus.wb_data, bus.wb_iv, bus.wb_rd); end
        n_cmp++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", bus.timeout_err); end
        n_cmp++; if (bus.fflags !== 5'b00011) begin n_fail++; $display("FAIL to_fflags: got %b want 00011", bus.fflags); end
        bus.exu_iv   = 1'b0;
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready     = 1'b0;
        bus.exu_result   = 16'h3C00;
        bus.exu_complete = 1'b1;
        drive_req(5'd10, 1'b0, 16'h5555, 16'h0000);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h00003C00 || bus.wb_rd !== 5'd10) begin n_fail++; $display("FAIL to_next_op: got %b %h rd %0d want 1 00003c00 rd 10", bus.wb_valid, bus.wb_data, bus.wb_rd); end
        n_cmp++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b want 1", bus.timeout_err); end
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready     = 1'b0;
        bus.exu_complete = 1'b0;
    endtask

    task automatic test_flag_clr();
        bus.fflags_clr = 1'b1;
        tick();
        bus.fflags_clr = 1'b0;
        n_cmp++; if (bus.fflags !== 5'b00000) begin n_fail++; $display("FAIL clr_plain: got %b want 00000", bus.fflags); end
        bus.exu_complete = 1'b1;
        bus.exu_flags    = 5'b10000;
        drive_req(5'd11, 1'b0, 16'h0000, 16'h0000);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.fflags !== 5'b10000) begin n_fail++; $display("FAIL clr_setup: got %b want 10000", bus.fflags); end
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready  = 1'b0;
        bus.exu_flags = 5'b00100;
        drive_req(5'd12, 1'b0, 16'h0000, 16'h0000);
        tick();
        bus.req_valid = 1'b0;
        tick();                                   // ISSUE: clear collides with completion
        bus.fflags_clr = 1'b1;
        tick();
        bus.fflags_clr = 1'b0;
        n_cmp++; if (bus.fflags !== 5'b00100) begin n_fail++; $display("FAIL clr_collision: got %b want 00100", bus.fflags); end
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready     = 1'b0;
        bus.exu_complete = 1'b0;
        bus.exu_flags    = 5'b00000;
    endtask

    task automatic test_reset_mid_wait();
        drive_req(5'd13, 1'b0, 16'hAAAA, 16'h0000);
        tick();
        drive_req(5'd14, 1'b0, 16'hBBBB, 16'h0000);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();                                   // WAIT with one op queued
        n_cmp++; if (bus.busy !== 1'b1 || bus.exu_fs1 !== 16'hAAAA) begin n_fail++; $display("FAIL rw_pre: got busy %b fs1 %h want 1 aaaa", bus.busy, bus.exu_fs1); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.busy !== 1'b0 || bus.exu_valid !== 1'b0 || bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL rw_ctrl_zero: got busy %b exu %b wb %b want 0/0/0", bus.busy, bus.exu_valid, bus.wb_valid); end
        n_cmp++; if (bus.exu_op !== 24'h0 || bus.exu_fs1 !== 16'h0 || bus.wb_rd !== 5'd0) begin n_fail++; $display("FAIL rw_fields_zero: got %h/%h/%0d want 0/0/0", bus.exu_op, bus.exu_fs1, bus.wb_rd); end
        n_cmp++; if (bus.fflags !== 5'b0 || bus.timeout_err !== 1'b0 || bus.wb_data !== 32'h0) begin n_fail++; $display("FAIL rw_status_zero: got %b/%b/%h want 0/0/0", bus.fflags, bus.timeout_err, bus.wb_data); end
        tick();
        rst = 1'b0;
        bus.exu_complete    = 1'b1;
        bus.exu_complete_rd = 1'b1;
        bus.exu_result      = 16'h7777;
        repeat (3) tick();
        n_cmp++; if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b0 || bus.exu_valid !== 1'b0) begin n_fail++; $display("FAIL rw_late_complete: got wb %b busy %b exu %b want 0/0/0", bus.wb_valid, bus.busy, bus.exu_valid); end
        bus.exu_complete    = 1'b0;
        bus.exu_complete_rd = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst                 = 1'b1;
        bus.req_valid       = 1'b0;
        bus.req_op          = '0;
        bus.req_ctrl        = '0;
        bus.req_rnd         = '0;
        bus.req_pre         = '0;
        bus.req_sel         = '0;
        bus.req_fs1         = '0;
        bus.req_fs2         = '0;
        bus.req_fs3         = '0;
        bus.req_rd          = '0;
        bus.req_int         = 1'b0;
        bus.exu_result      = '0;
        bus.exu_result_rd   = '0;
        bus.exu_complete    = 1'b0;
        bus.exu_complete_rd = 1'b0;
        bus.exu_flags       = '0;
        bus.exu_iv          = 1'b0;
        bus.wb_ready        = 1'b0;
        bus.fflags_clr      = 1'b0;

        test_reset();
        test_single_fp();
        test_int_op();
        test_fifo_full();
        test_timeout();
        test_flag_clr();
        test_reset_mid_wait();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
